// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared fetch-stage types and constants
package inst_fetch_unit_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 7;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// rtl/inst_fetch_unit_fetch_fifo.sv - {pc, instr} buffer with flush and combinational head
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [AW:0]      count_o,
    output logic [WIDTH-1:0] head_o
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push_i && (r_count < CNT_FULL);
    assign w_pop  = pop_i && (r_count != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - sequential PC fetch with credit-limited buffer and redirect flush
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                imem_req_o,
    output logic [31:0]         imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [INSTR_W-1:0]  imem_data_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [31:0]         pc_o,
    output logic [OPCODE_W-1:0] opcode_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_req_pc_next;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic [63:0]  w_head;
    logic         w_push;
    logic         w_pop;
    logic         w_issue;

    assign w_push       = (r_state == FETCH_REQ) && imem_ack_i && !redirect_i;
    assign w_pop        = instr_valid_o && instr_ready_i && !redirect_i;
    assign w_count_next = w_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    // A new request is only launched if its word is guaranteed a slot.
    assign w_issue      = !redirect_i && (w_count_next < CW'(DEPTH));

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_req_pc_next = r_req_pc;
        case (r_state)
            FETCH_IDLE: begin
                if (w_issue) begin
                    w_state_next  = FETCH_REQ;
                    w_req_pc_next = r_pc;
                    w_pc_next     = r_pc + PC_STEP;
                end
            end
            FETCH_REQ: begin
                if (imem_ack_i) begin
                    if (w_issue) begin
                        w_req_pc_next = r_pc;
                        w_pc_next     = r_pc + PC_STEP;
                    end else begin
                        w_state_next = FETCH_IDLE;
                    end
                end else if (redirect_i) begin
                    w_state_next = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (imem_ack_i) begin
                    w_state_next = FETCH_IDLE;
                end
            end
            default: w_state_next = FETCH_IDLE;
        endcase
        if (redirect_i) begin
            w_pc_next = align_pc(redirect_pc_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= FETCH_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_req_pc <= w_req_pc_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i ({r_req_pc, imem_data_i}),
        .pop_i       (w_pop),
        .flush_i     (redirect_i),
        .count_o     (w_count),
        .head_o      (w_head)
    );

    assign imem_req_o    = (r_state != FETCH_IDLE);
    assign imem_addr_o   = r_req_pc;
    assign instr_valid_o = (w_count != '0);
    assign instr_o       = w_head[31:0];
    assign pc_o          = w_head[63:32];
    assign opcode_o      = w_head[OPCODE_W-1:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized bench for inst_fetch_unit against a transaction model
module tb_inst_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [6:0]  opcode_o;

    always #5 clk = ~clk;

    inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .opcode_o      (opcode_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    int rel   = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        case (a[3:2])
            2'd0:    op = 7'h33;
            2'd1:    op = 7'h13;
            2'd2:    op = 7'h03;
            default: op = 7'h63;
        endcase
        return {a[26:2] ^ 25'h1234567, op};
    endfunction

    // Memory responder: mode 0 fixed latency, 1 random latency, 2 free-running ack toggle
    int   mem_mode = 0;
    int   lat      = 0;
    int   mw       = 0;
    logic m_prev_req = 1'b0;
    logic m_prev_ack = 1'b0;

    always @(posedge clk) begin
        #1;
        if (imem_req_o && (!m_prev_req || m_prev_ack)) mw = 0;
        else if (imem_req_o) mw++;
        case (mem_mode)
            0:       imem_ack_i = imem_req_o && (mw == lat);
            1:       imem_ack_i = imem_req_o && (($urandom % 3 == 0) || mw >= 4);
            default: imem_ack_i = ~imem_ack_i;
        endcase
        imem_data_i = mem_word(imem_addr_o);
        m_prev_req  = imem_req_o;
        m_prev_ack  = imem_ack_i;
    end

    // Transaction model and logs
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_next   = RESET_PC;
    bit          cur_drop = 1'b0;
    bit          p_req    = 1'b0;
    bit          p_ack    = 1'b0;
    bit          p_rst    = 1'b0;
    logic [31:0] p_addr   = '0;
    bit          nr;

    logic [31:0] req_addr[$];
    logic [31:0] req_cyc[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_ins[$];
    logic [31:0] dlv_cyc[$];

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_logs();
        req_addr.delete();
        req_cyc.delete();
        dlv_pc.delete();
        dlv_ins.delete();
        dlv_cyc.delete();
    endtask

    always @(negedge clk) begin
        if (p_rst) begin
            chk("rst_req",   {31'd0, imem_req_o},    32'd0);
            chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
            chk("rst_addr",  imem_addr_o,            32'd0);
            chk("rst_instr", instr_o,                32'd0);
            chk("rst_pc",    pc_o,                   32'd0);
            chk("rst_op",    {25'd0, opcode_o},      32'd0);
        end else begin
            if (p_req && !p_ack) begin
                chk("hold_req",  {31'd0, imem_req_o}, 32'd1);
                chk("hold_addr", imem_addr_o,         p_addr);
            end
            nr = imem_req_o && (!p_req || p_ack);
            if (nr) begin
                chk("req_addr", imem_addr_o, m_next);
                m_next   = m_next + 32'd4;
                cur_drop = 1'b0;
                req_addr.push_back(imem_addr_o);
                req_cyc.push_back(cyc_n);
            end
            chk("valid", {31'd0, instr_valid_o}, {31'd0, mq.size() != 0});
            if (instr_valid_o && mq.size() != 0) begin
                chk("head_pc",    pc_o,              mq[0].pc);
                chk("head_instr", instr_o,           mq[0].ins);
                chk("head_op",    {25'd0, opcode_o}, {25'd0, mq[0].ins[6:0]});
            end
            chk("occupancy", {31'd0, mq.size() > DEPTH}, 32'd0);
        end
        if (!rst_i) begin
            mq.delete();
            m_next   = RESET_PC;
            cur_drop = 1'b0;
            p_req    = 1'b0;
            p_ack    = 1'b0;
            p_rst    = 1'b1;
        end else begin
            if (instr_valid_o && instr_ready_i && !redirect_i && mq.size() != 0) begin
                dlv_pc.push_back(mq[0].pc);
                dlv_ins.push_back(mq[0].ins);
                dlv_cyc.push_back(cyc_n);
                void'(mq.pop_front());
            end
            if (imem_req_o && imem_ack_i && !cur_drop && !redirect_i)
                mq.push_back('{pc: imem_addr_o, ins: mem_word(imem_addr_o)});
            if (redirect_i) begin
                mq.delete();
                m_next = {redirect_pc_i[31:2], 2'b00};
                if (imem_req_o && !imem_ack_i) cur_drop = 1'b1;
            end
            p_req  = imem_req_o;
            p_ack  = imem_ack_i;
            p_addr = imem_addr_o;
            p_rst  = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        step(1);
        rst_i = 1'b0;
        step(n);
        rst_i = 1'b1;
        rel   = cyc_n;
        clear_logs();
    endtask

    int hits;
    bit found;

    initial begin
        rst_i = 1'b0; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_ack_i = 1'b0; imem_data_i = '0;

        // Zero-wait memory, decode always ready
        instr_ready_i = 1'b1; lat = 0;
        apply_reset(3);
        step(10);
        chk("t1_a0", qget(req_addr, 0), 32'd0);
        chk("t1_a1", qget(req_addr, 1), 32'd4);
        chk("t1_a2", qget(req_addr, 2), 32'd8);
        chk("t1_a3", qget(req_addr, 3), 32'd12);
        chk("t1_first_req", qget(req_cyc, 0), rel + 1);
        chk("t1_req_span", qget(req_cyc, 3) - qget(req_cyc, 0), 32'd3);
        chk("t1_p0", qget(dlv_pc, 0), 32'd0);
        chk("t1_p1", qget(dlv_pc, 1), 32'd4);
        chk("t1_p2", qget(dlv_pc, 2), 32'd8);
        chk("t1_i1", qget(dlv_ins, 1), 32'h91A2_B313);
        chk("t1_lat", qget(dlv_cyc, 0) - qget(req_cyc, 0), 32'd1);
        chk("t1_rate", qget(dlv_cyc, 2) - qget(dlv_cyc, 0), 32'd2);

        // Decode stalled: buffer fills to DEPTH and requests stop
        instr_ready_i = 1'b0;
        apply_reset(2);
        step(10);
        chk("t2_nreq",  req_addr.size(), 32'd2);
        chk("t2_req",   {31'd0, imem_req_o},    32'd0);
        chk("t2_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("t2_pc",    pc_o,    32'd0);
        chk("t2_instr", instr_o, 32'h91A2_B3B3);
        instr_ready_i = 1'b1;
        step(10);
        chk("t2_a2", qget(req_addr, 2), 32'd8);
        chk("t2_p0", qget(dlv_pc, 0), 32'd0);
        chk("t2_p1", qget(dlv_pc, 1), 32'd4);
        chk("t2_p2", qget(dlv_pc, 2), 32'd8);
        chk("t2_p3", qget(dlv_pc, 3), 32'd12);

        // Three-cycle memory latency
        lat = 3;
        apply_reset(2);
        step(14);
        chk("t3_a1",   qget(req_addr, 1), 32'd4);
        chk("t3_hold", qget(req_cyc, 1) - qget(req_cyc, 0), 32'd4);
        chk("t3_p0",   qget(dlv_pc, 0), 32'd0);
        chk("t3_p1",   qget(dlv_pc, 1), 32'd4);
        chk("t3_dgap", qget(dlv_cyc, 1) - qget(dlv_cyc, 0), 32'd4);

        // Redirect while the request for 8 is outstanding
        apply_reset(2);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (imem_req_o && imem_addr_o == 32'd8) found = 1'b1;
            else step(1);
        end
        chk("t4_wait", {31'd0, found}, 32'd1);
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        step(1);
        redirect_i = 1'b0;
        clear_logs();
        chk("t4_empty", {31'd0, instr_valid_o}, 32'd0);
        chk("t4_drop_req",  {31'd0, imem_req_o}, 32'd1);
        chk("t4_drop_addr", imem_addr_o, 32'd8);
        step(20);
        hits = 0;
        foreach (dlv_pc[i]) if (dlv_pc[i] == 32'd8) hits++;
        chk("t4_no8", hits, 32'd0);
        chk("t4_a0", qget(req_addr, 0), 32'h100);
        chk("t4_p0", qget(dlv_pc, 0), 32'h100);

        // Redirect to a misaligned address at the top of the space
        lat = 0;
        step(5);
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        step(1);
        redirect_i = 1'b0;
        clear_logs();
        step(8);
        chk("t5_a0", qget(req_addr, 0), 32'hFFFF_FFFC);
        chk("t5_a1", qget(req_addr, 1), 32'h0);
        chk("t5_a2", qget(req_addr, 2), 32'h4);
        chk("t5_p0", qget(dlv_pc, 0), 32'hFFFF_FFFC);
        chk("t5_p1", qget(dlv_pc, 1), 32'h0);

        // Reset in the middle of a request with ack pulsing
        lat = 2;
        step(3);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (imem_req_o) found = 1'b1;
            else step(1);
        end
        chk("t6_wait", {31'd0, found}, 32'd1);
        mem_mode = 2;
        rst_i = 1'b0;
        step(1);
        chk("t6_req",   {31'd0, imem_req_o},    32'd0);
        chk("t6_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t6_addr",  imem_addr_o, 32'd0);
        chk("t6_pc",    pc_o,        32'd0);
        step(2);
        mem_mode = 0; lat = 0;
        rst_i = 1'b1;
        rel = cyc_n;
        clear_logs();
        step(8);
        chk("t6_a0",    qget(req_addr, 0), RESET_PC);
        chk("t6_first", qget(req_cyc, 0), rel + 1);
        chk("t6_p0",    qget(dlv_pc, 0), RESET_PC);
        chk("t6_i0",    qget(dlv_ins, 0), 32'h91A2_B3B3);
        chk("t6_p1",    qget(dlv_pc, 1), 32'd4);

        // Random latency, backpressure and redirects
        mem_mode = 1;
        clear_logs();
        for (int k = 0; k < 3000; k++) begin
            instr_ready_i = ($urandom % 4) != 0;
            redirect_i    = ($urandom % 32) == 0;
            redirect_pc_i = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            step(1);
        end
        redirect_i = 1'b0;
        instr_ready_i = 1'b1;
        step(20);
        chk("rand_progress", {31'd0, dlv_pc.size() > 200}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Front end of the pipeline: generates sequential PCs, requests instruction words from the instruction-memory/cache port, buffers returned words in a small FIFO, and delivers {pc, instr, opcode} to the decode/control stage over a valid/ready handshake. Handles branch redirects by flushing the buffer and discarding in-flight responses. Tolerates multi-cycle cache latency; sustains 1 instr/cycle with zero-wait memory.

Parameters:
DEPTH, 2, instruction buffer entries (power of two, >=2)
RESET_PC, 32'h0000_0000, PC fetched first after reset

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous, active-low reset
imem_req_o  output  1  fetch request; held high until acked
imem_addr_o  output  32  fetch address; stable while imem_req_o high
imem_ack_i  input  1  memory accepts request and returns data this cycle
imem_data_i  input  32  instruction word, valid when imem_ack_i
redirect_i  input  1  branch taken / flush request
redirect_pc_i  input  32  new fetch PC; bits [1:0] ignored (forced 0)
instr_valid_o  output  1  buffer head valid
instr_ready_i  input  1  decode stage accepts head
instr_o  output  32  head instruction word
pc_o  output  32  head PC
opcode_o  output  7  instr_o[6:0], feeds control decoder Op_i

Behaviour:
- Reset (rst_i==0 at edge): pc<=RESET_PC, FIFO empty, state IDLE, imem_req_o=0, instr_valid_o=0, imem_addr_o=0, instr_o=0, pc_o=0.
- States: IDLE (no request), REQ (request outstanding, result kept), DROP (request outstanding, result discarded). imem_req_o=1 in REQ and DROP; imem_addr_o=req_pc register.
- Credit: count_next = count + push - pop. Issue allowed only when count_next < DEPTH and redirect_i==0; FIFO can therefore never overflow.
- IDLE: if issue allowed -> REQ, req_pc<=pc, pc<=pc+4. First request appears the cycle after reset release.
- REQ, ack, no redirect: push {req_pc, imem_data_i}; if issue allowed, stay REQ with next req_pc (back-to-back), else IDLE.
- REQ, no ack: hold req/addr stable.
- Redirect (any state): FIFO flushed (count<=0, pop ignored), pc<=redirect_pc_i&~3. REQ+no ack -> DROP. REQ+ack -> data discarded, IDLE. DROP stays DROP. IDLE stays IDLE. Next issue earliest the cycle after redirect.
- DROP, ack: discard data, -> IDLE. Outstanding requests are never withdrawn (bus rule).
- Output: instr_valid_o = (count!=0); instr_o/pc_o/opcode_o = FIFO head (combinational from storage); pop on instr_valid_o&&instr_ready_i. Head must stay stable while valid and not ready.
- Simultaneous push and pop: both take effect; order preserved.
- PC arithmetic: 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Reset mid-request: all state cleared; a late imem_ack_i during/after reset while IDLE is ignored.
- Throughput: zero-wait ack and ready held high -> one instruction per cycle after 2-cycle startup.

Decomposition:
- Shared package: fetch state encoding (IDLE/REQ/DROP), INSTR_W=32, OPCODE_W=7, PC_STEP=4, NOP word 32'h0000_0013, opcode constants already used by decode (7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011).
- Sub-module fetch_fifo: DEPTH x 64-bit {pc, instr} synchronous FIFO with push, pop, flush, count, head outputs; the FSM/PC logic remains in the top.

Test Plan:
- Reset release, ack tied 1, ready 1 -> addresses 0,4,8,12 on consecutive cycles; pc_o 0,4,8 with instr_o matching memory, one per cycle.
- ready held 0, zero-wait memory -> exactly DEPTH=2 words buffered (pc 0,4), imem_req_o drops to 0, head stable; ready=1 resumes at pc 8, no loss or duplication.
- Ack delayed 3 cycles -> addr 0 held stable for 4 cycles, single push, then next request addr 4.
- Redirect to 32'h100 while request for 8 is pending -> FIFO empties next cycle, state DROP, word for 8 never appears; next request addr 32'h100, first delivered pc_o 32'h100.
- redirect_pc_i=32'hFFFF_FFFE -> fetch addr 32'hFFFF_FFFC then wraps to 0.
- rst_i asserted low mid-request with ack pulsing -> all outputs zero; after release first addr RESET_PC, no stale instruction delivered.
